dm_arbiter: RTL and testbench

Two-master arbiter for the shared data-memory port of the SoC. It multiplexes the CPU data interface (master 0) and a loader/debug DMA master (master 1) onto the single synchronous-read byte-lane RAM plus peripheral bus. It grants one transfer per cycle and tracks which master owns the in-flight read. It supports bus locking for atomic read-modify-write sequences.

---
 rtl/dm_arbiter_pkg.sv | 10 +
 rtl/dm_arb_pick.sv | 18 +
 rtl/dm_arbiter.sv | 84 ++++++++
 tb/tb_dm_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: FSM state encodings and master IDs shared by the dm_arbiter slice.
package dm_arbiter_pkg;
  typedef enum logic [1:0] {
    DM_ARB_IDLE = 2'd0,
    DM_ARB_OWN0 = 2'd1,
    DM_ARB_OWN1 = 2'd2
  } state_e;
  localparam logic DM_ARB_M0 = 1'b0;
  localparam logic DM_ARB_M1 = 1'b1;
endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational one-hot 2-way picker; DM_ARB_ROUND_ROBIN_EN selects round-robin, else m0 wins ties.
module dm_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);
  logic [1:0] r;
  assign r = req & mask;
`ifdef DM_ARB_ROUND_ROBIN_EN
  // last=1 means m1 won previously, so m0 takes the tie
  assign gnt = (r == 2'b11) ? (last ? 2'b01 : 2'b10) : r;
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt = r[0] ? 2'b01 : {r[1], 1'b0};
`endif
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter with lock ownership and read tracking for the shared data-memory port.
// Build option DM_ARB_ROUND_ROBIN_EN enables round-robin tie-break; default is fixed m0 priority.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic            m0_lock_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic            m1_lock_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            s_ce_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_rdata_i
);
  state_e     state, state_n;
  logic [1:0] gnt, mask;
  logic       last, rd_pend, rd_owner;
  assign mask = (state == DM_ARB_OWN0) ? 2'b01 : (state == DM_ARB_OWN1) ? 2'b10 : 2'b11;
  dm_arb_pick u_pick (
    .req  ({m1_req_i, m0_req_i}),
    .last (last),
    .mask (mask),
    .gnt  (gnt)
  );
  // in OWNn only master n can be granted, so any unlocked grant releases ownership
  always_comb begin
    state_n = state;
    if (state == DM_ARB_IDLE)
      state_n = (gnt[0] && m0_lock_i) ? DM_ARB_OWN0 : (gnt[1] && m1_lock_i) ? DM_ARB_OWN1 : DM_ARB_IDLE;
    else if ((gnt[0] && !m0_lock_i) || (gnt[1] && !m1_lock_i))
      state_n = DM_ARB_IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= DM_ARB_IDLE;
      rd_pend  <= 1'b0;
      rd_owner <= DM_ARB_M0;
    end else begin
      state   <= state_n;
      rd_pend <= s_ce_o && !s_we_o;
      if (s_ce_o && !s_we_o) rd_owner <= gnt[1] ? DM_ARB_M1 : DM_ARB_M0;
    end
  end
`ifdef DM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
`else
  assign last = 1'b1;
`endif
  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign s_ce_o      = |gnt;
  assign s_we_o      = gnt[1] ? m1_we_i    : gnt[0] && m0_we_i;
  assign s_addr_o    = gnt[1] ? m1_addr_i  : gnt[0] ? m0_addr_i  : '0;
  assign s_wdata_o   = gnt[1] ? m1_wdata_i : gnt[0] ? m0_wdata_i : '0;
  assign s_sel_o     = gnt[1] ? m1_sel_i   : gnt[0] ? m0_sel_i   : '0;
  assign m0_rvalid_o = rd_pend && (rd_owner == DM_ARB_M0);
  assign m1_rvalid_o = rd_pend && (rd_owner == DM_ARB_M1);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a synchronous-read slave model.
module tb_dm_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        m0_req_i, m0_we_i, m0_lock_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_ce_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_sel_o;
  int checks = 0, errors = 0;
  dm_arbiter #(.AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_lock_i(m0_lock_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_lock_i(m1_lock_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_sel_o(s_sel_o), .s_rdata_i(s_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  // slave returns address XOR a fixed pattern one cycle after a load strobe
  always_ff @(posedge clk_i) if (s_ce_o && !s_we_o) s_rdata_i <= s_addr_o ^ 32'hA5A5_0000;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_in();
    m0_req_i = 0; m0_we_i = 0; m0_lock_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_sel_i = 4'hF;
    m1_req_i = 0; m1_we_i = 0; m1_lock_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_sel_i = 4'hF;
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    idle_in();
    rst_i = 1;
    step();
    step();
    rst_i = 0;
    #1;
  endtask
  logic [1:0] exp_g [4];
  logic       lk [3];
  initial begin
`ifdef DM_ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    lk = '{1'b1, 1'b1, 1'b0};
    do_reset();
    check("rst_m0_rvalid", m0_rvalid_o, 0);
    check("rst_m1_rvalid", m1_rvalid_o, 0);
    check("rst_s_ce", s_ce_o, 0);
    check("rst_gnt", {m1_gnt_o, m0_gnt_o}, 0);
    check("rst_state", dut.state, 0);
    m0_req_i = 1; m0_addr_i = 32'h10;
    #1;
    check("ld_gnt", {m1_gnt_o, m0_gnt_o}, 2'b01);
    check("ld_s_ce", s_ce_o, 1);
    check("ld_s_addr", s_addr_o, 32'h10);
    check("ld_s_we", s_we_o, 0);
    step(); idle_in(); #1;
    check("ld_m0_rvalid", m0_rvalid_o, 1);
    check("ld_m0_rdata", m0_rdata_o, 32'hA5A5_0010);
    check("ld_m1_rvalid", m1_rvalid_o, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req_i = 1; m0_addr_i = 32'h100; m1_req_i = 1; m1_addr_i = 32'h200;
      #1;
      check($sformatf("tie_gnt%0d", i), {m1_gnt_o, m0_gnt_o}, exp_g[i]);
      step();
    end
    idle_in();
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h80; m1_wdata_i = 32'hDEAD_BEEF; m1_sel_i = 4'b0011;
    #1;
    check("st_gnt", {m1_gnt_o, m0_gnt_o}, 2'b10);
    check("st_s_ce", s_ce_o, 1);
    check("st_s_we", s_we_o, 1);
    check("st_s_sel", s_sel_o, 4'b0011);
    check("st_s_wdata", s_wdata_o, 32'hDEAD_BEEF);
    check("st_s_addr", s_addr_o, 32'h80);
    step(); idle_in(); #1;
    check("st_rvalid", {m1_rvalid_o, m0_rvalid_o}, 0);
    m1_req_i = 1; m1_lock_i = 1; m1_addr_i = 32'h300;
    #1;
    check("lk_first_gnt", {m1_gnt_o, m0_gnt_o}, 2'b10);
    step();
    check("lk_state_own1", dut.state, 2);
    for (int i = 0; i < 3; i++) begin
      m0_req_i = 1; m0_addr_i = 32'h400; m1_req_i = 1; m1_lock_i = lk[i];
      #1;
      check($sformatf("lk_gnt%0d", i), {m1_gnt_o, m0_gnt_o}, 2'b10);
      step();
      check($sformatf("lk_state%0d", i), dut.state, (i < 2) ? 2 : 0);
    end
    m1_req_i = 0; m1_lock_i = 0;
    #1;
    check("lk_m0_after", {m1_gnt_o, m0_gnt_o}, 2'b01);
    step();
    idle_in();
    m0_req_i = 1; m0_addr_i = 32'h20;
    #1;
    check("b2b_gnt0", {m1_gnt_o, m0_gnt_o}, 2'b01);
    step(); idle_in();
    m1_req_i = 1; m1_addr_i = 32'h40;
    #1;
    check("b2b_gnt1", {m1_gnt_o, m0_gnt_o}, 2'b10);
    check("b2b_n1_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
    check("b2b_m0_rdata", m0_rdata_o, 32'hA5A5_0020);
    step(); idle_in(); #1;
    check("b2b_n2_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b10);
    check("b2b_m1_rdata", m1_rdata_o, 32'hA5A5_0040);
    m0_req_i = 1; m0_lock_i = 1; m0_addr_i = 32'h50;
    #1;
    check("ar_gnt", {m1_gnt_o, m0_gnt_o}, 2'b01);
    step(); idle_in(); #1;
    check("ar_rvalid_pre", m0_rvalid_o, 1);
    check("ar_state_own0", dut.state, 1);
    rst_i = 1;
    #1;
    check("ar_rvalid_async", m0_rvalid_o, 0);
    check("ar_state_idle", dut.state, 0);
    rst_i = 0;
    step();
    check("ar_rvalid_after", {m1_rvalid_o, m0_rvalid_o}, 0);
    m1_req_i = 1; m1_addr_i = 32'h60;
    #1;
    check("ar_lock_released", {m1_gnt_o, m0_gnt_o}, 2'b10);
    step(); idle_in();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
